// File: rtl/pwm_capture.sv
// pwm_capture: measures period and high time of a PWM input in clk cycles.
// Ports: clk, rst_n (async low), in (PWM), clr (sync clear) ->
//   period/high (16b results), valid (1-cycle pulse), ovf (sticky timeout),
//   meas (state is MEAS).
// Build option: define PWM_CAPTURE_SYNC_EN to pass `in` through a
//   two-flop synchronizer (edges and valid arrive 2 cycles later).
module pwm_capture (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in,
    input  logic        clr,
    output logic [15:0] period,
    output logic [15:0] high,
    output logic        valid,
    output logic        ovf,
    output logic        meas
);

    typedef enum logic {
        IDLE = 1'b0,
        MEAS = 1'b1
    } state_t;

    state_t      state_q;
    logic        s;
    logic        s_q;
    logic [15:0] cnt_q;
    logic [15:0] hcap_q;
    logic [15:0] period_q;
    logic [15:0] high_q;
    logic        valid_q;
    logic        ovf_q;
    logic        meas_q;
    logic        rise;
    logic        fall;

`ifdef PWM_CAPTURE_SYNC_EN
    logic [1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], in};
        end
    end

    assign s = sync_q[1];
`else
    assign s = in;
`endif

    assign rise = s & ~s_q;
    assign fall = ~s & s_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            s_q      <= 1'b0;
            cnt_q    <= 16'd0;
            hcap_q   <= 16'd0;
            period_q <= 16'd0;
            high_q   <= 16'd0;
            valid_q  <= 1'b0;
            ovf_q    <= 1'b0;
            meas_q   <= 1'b0;
        end else begin
            // Edge history keeps tracking even while clr is held, so an
            // edge swallowed by clr is not re-detected afterwards.
            s_q     <= s;
            valid_q <= 1'b0;
            if (clr) begin
                state_q  <= IDLE;
                meas_q   <= 1'b0;
                cnt_q    <= 16'd0;
                hcap_q   <= 16'd0;
                period_q <= 16'd0;
                high_q   <= 16'd0;
                ovf_q    <= 1'b0;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        if (rise) begin
                            state_q <= MEAS;
                            meas_q  <= 1'b1;
                            cnt_q   <= 16'd1;
                        end
                    end
                    MEAS: begin
                        if (fall) begin
                            hcap_q <= cnt_q;
                        end
                        // A rise in the timeout cycle still measures.
                        if (rise) begin
                            period_q <= cnt_q;
                            high_q   <= hcap_q;
                            cnt_q    <= 16'd1;
                            valid_q  <= 1'b1;
                        end else if (cnt_q == 16'hFFFF) begin
                            state_q <= IDLE;
                            meas_q  <= 1'b0;
                            ovf_q   <= 1'b1;
                            cnt_q   <= 16'd0;
                        end else begin
                            cnt_q <= cnt_q + 16'd1;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        meas_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign period = period_q;
    assign high   = high_q;
    assign valid  = valid_q;
    assign ovf    = ovf_q;
    assign meas   = meas_q;

endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: directed bench for pwm_capture.
// Per-scenario tasks with inline checks and one summary line.
module tb_pwm_capture;

`ifdef PWM_CAPTURE_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic        clk;
    logic        rst_n;
    logic        in;
    logic        clr;
    logic [15:0] period;
    logic [15:0] high;
    logic        valid;
    logic        ovf;
    logic        meas;

    int errors;
    int checks;
    int cyc;

    pwm_capture dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .in     (in),
        .clr    (clr),
        .period (period),
        .high   (high),
        .valid  (valid),
        .ovf    (ovf),
        .meas   (meas)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Drives n periods (p, h) then tail low cycles; reports valid stats.
    task automatic run_wave(
        input  int p,
        input  int h,
        input  int n,
        input  int tail,
        output int nv,
        output int bad,
        output int first,
        output int span,
        output int last_rise
    );
        bit is_rise;
        nv        = 0;
        bad       = 0;
        first     = -1;
        span      = 0;
        last_rise = 0;
        for (int i = 0; i < n * p + tail; i++) begin
            is_rise = (i < n * p) && ((i % p) == 0);
            in = (i < n * p) && ((i % p) < h);
            tick();
            if (is_rise) last_rise = cyc;
            if (valid === 1'b1) begin
                nv++;
                if (first < 0) first = i;
                else span = i - first;
                if (period !== p[15:0] || high !== h[15:0]) bad++;
            end
        end
    endtask

    task automatic do_clr();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in    = 1'b0;
        clr   = 1'b0;
        #2;
        checks++;
        if ({period, high} !== 32'd0) begin
            errors++;
            $display("FAIL reset_ph: got %h want 0", {period, high});
        end
        checks++;
        if ({valid, ovf, meas} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags: got %b want 000", {valid, ovf, meas});
        end
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if (meas !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: meas got %b want 0", meas);
        end
    endtask

    task automatic test_basic();
        int nv, bad, first, span, lr;
        run_wave(100, 25, 4, 4, nv, bad, first, span, lr);
        checks++;
        if (nv !== 3) begin
            errors++;
            $display("FAIL basic_count: got %0d want 3", nv);
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL basic_values: bad=%0d want 0", bad);
        end
        checks++;
        if (first !== 100 + LAT) begin
            errors++;
            $display("FAIL basic_first: got %0d want %0d", first, 100 + LAT);
        end
        checks++;
        if (period !== 16'd100 || high !== 16'd25) begin
            errors++;
            $display("FAIL basic_hold: got %0d/%0d want 100/25", period, high);
        end
        checks++;
        if (meas !== 1'b1) begin
            errors++;
            $display("FAIL basic_meas: got %b want 1", meas);
        end
    endtask

    task automatic test_min();
        int nv, bad, first, span, lr;
        do_clr();
        run_wave(2, 1, 8, 4, nv, bad, first, span, lr);
        checks++;
        if (nv !== 7) begin
            errors++;
            $display("FAIL min_count: got %0d want 7", nv);
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL min_values: bad=%0d want 0", bad);
        end
        checks++;
        if (span !== 12) begin
            errors++;
            $display("FAIL min_spacing: span got %0d want 12", span);
        end
    endtask

    task automatic test_reset_mid();
        int nv, bad, first, span, lr;
        in = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({period, high} !== 32'd0) begin
            errors++;
            $display("FAIL rstmid_ph: got %h want 0", {period, high});
        end
        checks++;
        if ({valid, ovf, meas} !== 3'b000) begin
            errors++;
            $display("FAIL rstmid_flags: got %b want 000", {valid, ovf, meas});
        end
        tick();
        in = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        run_wave(30, 10, 3, 4, nv, bad, first, span, lr);
        checks++;
        if (nv !== 2 || bad !== 0) begin
            errors++;
            $display("FAIL rstmid_meas: nv=%0d bad=%0d want 2/0", nv, bad);
        end
        checks++;
        if (first !== 30 + LAT) begin
            errors++;
            $display("FAIL rstmid_first: got %0d want %0d", first, 30 + LAT);
        end
    endtask

    task automatic test_timeout();
        int nv, bad, first, span, lr;
        int waited;
        int spur;
        do_clr();
        run_wave(40, 10, 3, 4, nv, bad, first, span, lr);
        checks++;
        if (nv !== 2 || bad !== 0) begin
            errors++;
            $display("FAIL tmo_pre: nv=%0d bad=%0d want 2/0", nv, bad);
        end
        waited = 0;
        spur   = 0;
        in     = 1'b0;
        while (ovf !== 1'b1 && waited < 70000) begin
            tick();
            waited++;
            if (valid === 1'b1) spur++;
        end
        checks++;
        if (waited >= 70000) begin
            errors++;
            $display("FAIL tmo_bound: ovf got %b want 1", ovf);
        end
        checks++;
        if (cyc - lr !== 65535 + LAT) begin
            errors++;
            $display("FAIL tmo_time: got %0d want %0d", cyc - lr, 65535 + LAT);
        end
        for (int i = 0; i < 100; i++) begin
            tick();
            if (valid === 1'b1) spur++;
        end
        checks++;
        if (meas !== 1'b0 || ovf !== 1'b1 || spur !== 0) begin
            errors++;
            $display("FAIL tmo_state: meas=%b ovf=%b spur=%0d want 0/1/0", meas, ovf, spur);
        end
        checks++;
        if (period !== 16'd40 || high !== 16'd10) begin
            errors++;
            $display("FAIL tmo_hold: got %0d/%0d want 40/10", period, high);
        end
        run_wave(40, 10, 3, 4, nv, bad, first, span, lr);
        checks++;
        if (nv !== 2 || bad !== 0 || first !== 40 + LAT) begin
            errors++;
            $display("FAIL tmo_resume: nv=%0d bad=%0d first=%0d want 2/0/%0d", nv, bad, first, 40 + LAT);
        end
        checks++;
        if (ovf !== 1'b1) begin
            errors++;
            $display("FAIL tmo_sticky: ovf got %b want 1", ovf);
        end
    endtask

    task automatic test_clr_rise();
        int nv, bad, first, span, lr;
        int spur;
        run_wave(50, 20, 2, 0, nv, bad, first, span, lr);
        spur = 0;
        for (int i = 0; i < 50; i++) begin
            in  = (i < 20);
            clr = (i == LAT);
            tick();
            clr = 1'b0;
            if (i == LAT) begin
                checks++;
                if ({period, high} !== 32'd0) begin
                    errors++;
                    $display("FAIL clr_ph: got %h want 0", {period, high});
                end
                checks++;
                if ({valid, ovf, meas} !== 3'b000) begin
                    errors++;
                    $display("FAIL clr_flags: got %b want 000", {valid, ovf, meas});
                end
            end else if (i > LAT && valid === 1'b1) begin
                spur++;
            end
        end
        checks++;
        if (spur !== 0) begin
            errors++;
            $display("FAIL clr_novalid: got %0d pulses want 0", spur);
        end
        run_wave(50, 20, 3, 4, nv, bad, first, span, lr);
        checks++;
        if (nv !== 2 || bad !== 0 || first !== 50 + LAT) begin
            errors++;
            $display("FAIL clr_resume: nv=%0d bad=%0d first=%0d want 2/0/%0d", nv, bad, first, 50 + LAT);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        cyc    = 0;
        test_reset();
        test_basic();
        test_min();
        test_reset_mid();
        test_timeout();
        test_clr_rise();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pwm_capture.md
PWM_CAPTURE -- requirements
Module: pwm_capture

Interface
REQ-001 The block SHALL have exactly one clock and SHALL use an asynchronous, active-low reset.
REQ-002 clk  input  1  the block's single clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  asynchronous reset, active low.
REQ-004 in  input  1  PWM waveform to be measured.
REQ-005 clr  input  1  synchronous clear of measurements, the ovf flag and the state machine.
REQ-006 period  output  16  last measured period, in clk cycles between consecutive rising edges of s.
REQ-007 high  output  16  last measured high time, in clk cycles from a rising edge of s to the following falling edge.
REQ-008 valid  output  1  one-cycle pulse marking a new period/high pair.
REQ-009 ovf  output  1  sticky flag; set when no rising edge occurs within 65535 cycles.
REQ-010 meas  output  1  high while the state machine is in MEAS.

Function
REQ-011 s SHALL denote the internal sampled input (see Configuration); s_q SHALL be s delayed by one clk cycle.
REQ-012 A rise SHALL be s=1 with s_q=0; a fall SHALL be s=0 with s_q=1.
REQ-013 States SHALL be IDLE and MEAS, with a 16-bit counter cnt and a 16-bit high-capture register hcap.
REQ-014 IDLE, on rise: go to MEAS and load cnt=1; no valid pulse.
REQ-015 MEAS, in every cycle without a rise: increment cnt by 1.
REQ-016 MEAS, on fall: load hcap with the current cnt, so hcap = cycles from the rise to the fall.
REQ-017 MEAS, on rise: load period with the current cnt and high with hcap, reload cnt=1, stay in MEAS, and assert valid in the next cycle only.
REQ-018 period and high SHALL change only in the cycle before valid, or on clr or reset, and SHALL hold otherwise.
REQ-019 Minimum supported waveform: period 2, high 1; results SHALL be exact from 2 to 65535.
REQ-020 Timeout: in MEAS with cnt=16'hFFFF and no rise, go to IDLE and set ovf; period and high hold; no valid pulse.
- A constant input (0% or 100% duty) therefore yields ovf=1 and meas=0.
REQ-021 A rise in the timeout cycle SHALL take priority over the timeout: measure normally, leave ovf unchanged.
REQ-022 ovf SHALL remain set until clr or reset.
REQ-023 clr=1 SHALL force IDLE and zero period, high, cnt, hcap, ovf and valid in the next cycle.
- clr SHALL win over a simultaneous rise, fall or timeout.
REQ-024 An edge arriving in the cycle clr is asserted SHALL be ignored; s_q still updates.
REQ-025 The first valid after IDLE SHALL come after the second detected rise, never the first.

Reset
REQ-026 rst_n=0 SHALL immediately, without waiting for clk, set state=IDLE and set period, high, cnt, hcap, valid, ovf, meas, s_q and any synchronizer flops to 0.
REQ-027 Reset mid-measurement SHALL discard the partial measurement; after release, measurement restarts per REQ-025.
- If in is already 1 at release, that level SHALL count as a rise one cycle after s becomes 1.

Configuration
REQ-028 Macro PWM_CAPTURE_SYNC_EN SHALL select the input sampling path.
REQ-029 Defined: s SHALL be in passed through a two-flop synchronizer, adding 2 cycles of latency to edge detection and valid; measured values are unchanged.
REQ-030 Undefined: s SHALL be in directly; in must then be synchronous to clk.

Verification
REQ-031 Period 100, high 25, four periods, in synchronous to clk -> three valid pulses, each with period=100 and high=25; the first pulse follows the second rise.
REQ-032 Period 2, high 1 -> period=2 and high=1 on every valid, with valid asserted every 2 cycles.
REQ-033 Period 40 high 10, then in held at 0 for 70000 cycles -> ovf=1 and meas=0 after 65535 cycles from the last rise; period=40 and high=10 held.
- A new waveform then gives valid again after two rises, with ovf still 1.
REQ-034 clr asserted in the same cycle as a rise, during a period-50 stream -> period=0, high=0, ovf=0, no valid.
- Next valid comes after two further rises, showing period=50.
REQ-035 rst_n pulsed low mid-period, asynchronously to clk -> all outputs 0 immediately; the first valid comes after two rises following release.
REQ-036 Run the bench with and without PWM_CAPTURE_SYNC_EN -> identical period and high values; valid occurs 2 cycles later with the macro defined.
